// File: rtl/i2c_pkg.sv
// Shared types and constants for the 16-bit-pointer I2C register writer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package i2c_pkg;

  localparam int ADDR_W      = 8;
  localparam int PTR_W       = 16;
  localparam int DATA_W      = 16;
  localparam int MAX_PAYLOAD = 4;
  localparam int SHIFT_W     = ADDR_W + PTR_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST_A,
    S_ST_B,
    S_BIT,
    S_ACK,
    S_SP_A,
    S_SP_B,
    S_SP_C
  } state_t;

  typedef enum logic [1:0] {
    PH_Q0,
    PH_Q1,
    PH_Q2,
    PH_Q3
  } phase_t;

  // 0 is promoted to a single byte; anything above the payload limit is capped.
  function automatic logic [2:0] clamp_byte_num(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > 3'(MAX_PAYLOAD)) return 3'(MAX_PAYLOAD);
    return n;
  endfunction

  // Line levels {scl, sda} for a given state/phase; b is the current data bit.
  function automatic logic [1:0] line_levels(input state_t s, input phase_t p, input logic b);
    logic scl_hi;
    scl_hi = (p == PH_Q2) || (p == PH_Q3);
    case (s)
      S_IDLE:  return 2'b11;
      S_ST_A:  return 2'b11;
      S_ST_B:  return 2'b10;
      S_BIT:   return {scl_hi, b};
      S_ACK:   return {scl_hi, 1'b1};
      S_SP_A:  return 2'b00;
      S_SP_B:  return 2'b10;
      S_SP_C:  return 2'b11;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit divider: one-cycle tick every CLK_DIV+1 cycles while run is high.
// Latency: first tick CLK_DIV cycles after run rises; counter held at 0 while run is low.
// Backpressure: with I2C_WR_CLK_STRETCH_EN, holds in the stretch window while synced SCL reads low.
// Ports: clk, rst_n (async active-low), run, stretch_window (q2 of BIT/ACK),
//        scl_in (SCL pad, only used with I2C_WR_CLK_STRETCH_EN), tick (out).
module i2c_quarter_tick #(
  parameter int CLK_DIV     = 31,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic stretch_window,
  input  logic scl_in,
  output logic tick
);

  localparam int CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          hold;

`ifdef I2C_WR_CLK_STRETCH_EN
  logic [SYNC_STAGES-1:0] scl_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe <= '1;
    end else begin
      scl_pipe[0] <= scl_in;
      for (int i = 1; i < SYNC_STAGES; i++) scl_pipe[i] <= scl_pipe[i-1];
    end
  end

  // A slave holding SCL low freezes the quarter, including its terminal tick.
  assign hold = stretch_window && !scl_pipe[SYNC_STAGES-1];
`else
  logic unused_stretch;
  assign unused_stretch = stretch_window ^ scl_in;
  assign hold           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && !hold && (cnt == CNT_MAX);

endmodule

// File: rtl/i2c_reg16_writer.sv
// I2C master: START, address byte, 1-4 payload bytes from {pointer, data}, ACK checks, STOP.
// Latency: DONE at cycle Q*(CLK_DIV+1)+1 after GO, Q = 2 + 36*(bytes incl. address) + 3 quarters.
// Backpressure: GO honoured only in IDLE (not in the DONE cycle); NACK aborts straight to STOP.
// Ports: CLK_50, RESET_N (async active-low), GO, SLAVE_ADDR, POINTER, WDATA, BYTE_NUM,
//        SDA_I, SCL_I -> SDA_O, SCL_O (1 = release), BUSY, DONE, ACK_ERR (sticky), END_OK.
// Optional: define I2C_WR_CLK_STRETCH_EN to honour slave clock stretching via SCL_I.
module i2c_reg16_writer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV     = 31,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_50,
  input  logic              RESET_N,
  input  logic              GO,
  input  logic [ADDR_W-1:0] SLAVE_ADDR,
  input  logic [PTR_W-1:0]  POINTER,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [2:0]        BYTE_NUM,
  input  logic              SDA_I,
  input  logic              SCL_I,
  output logic              SDA_O,
  output logic              SCL_O,
  output logic              BUSY,
  output logic              DONE,
  output logic              ACK_ERR,
  output logic              END_OK
);

  state_t             state, state_n;
  phase_t             phase, phase_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [2:0]         byte_cnt, byte_cnt_n;
  logic [2:0]         nbytes, nbytes_n;
  logic [SHIFT_W-1:0] shreg, shreg_n;
  logic               busy, busy_n;
  logic               done, done_n;
  logic               ack_err, ack_err_n;
  logic               sda_q, scl_q;
  logic [1:0]         lines_n;
  logic               tick;
  logic               stretch_window;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic               sda_in;

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sda_pipe <= '1;
    end else begin
      sda_pipe[0] <= SDA_I;
      for (int i = 1; i < SYNC_STAGES; i++) sda_pipe[i] <= sda_pipe[i-1];
    end
  end

  assign sda_in = sda_pipe[SYNC_STAGES-1];

  assign stretch_window = ((state == S_BIT) || (state == S_ACK)) && (phase == PH_Q2);

  i2c_quarter_tick #(
    .CLK_DIV     (CLK_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick (
    .clk            (CLK_50),
    .rst_n          (RESET_N),
    .run            (busy),
    .stretch_window (stretch_window),
    .scl_in         (SCL_I),
    .tick           (tick)
  );

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      phase    <= PH_Q0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      nbytes   <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      nbytes   <= nbytes_n;
      shreg    <= shreg_n;
      busy     <= busy_n;
      done     <= done_n;
      ack_err  <= ack_err_n;
      scl_q    <= lines_n[1];
      sda_q    <= lines_n[0];
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    nbytes_n   = nbytes;
    shreg_n    = shreg;
    busy_n     = busy;
    done_n     = 1'b0;
    ack_err_n  = ack_err;

    case (state)
      S_IDLE: begin
        // The DONE cycle is already IDLE, but a GO there is deliberately dropped.
        if (GO && !done) begin
          state_n    = S_ST_A;
          phase_n    = PH_Q0;
          bit_cnt_n  = '0;
          byte_cnt_n = '0;
          nbytes_n   = clamp_byte_num(BYTE_NUM);
          shreg_n    = {SLAVE_ADDR & 8'hFE, POINTER, WDATA};
          busy_n     = 1'b1;
          ack_err_n  = 1'b0;
        end
      end
      S_ST_A: if (tick) state_n = S_ST_B;
      S_ST_B: begin
        if (tick) begin
          state_n   = S_BIT;
          phase_n   = PH_Q0;
          bit_cnt_n = '0;
        end
      end
      S_BIT: begin
        if (tick) begin
          if (phase != PH_Q3) begin
            phase_n = phase_t'(phase + 2'd1);
          end else begin
            // Shift at the end of q3 so the next bit appears on SDA in q0.
            phase_n = PH_Q0;
            shreg_n = {shreg[SHIFT_W-2:0], 1'b0};
            if (bit_cnt == 3'd7) begin
              state_n   = S_ACK;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          case (phase)
            PH_Q2: begin
              if (sda_in) ack_err_n = 1'b1;
              phase_n = PH_Q3;
            end
            PH_Q3: begin
              phase_n = PH_Q0;
              // byte_cnt 0 is the address byte, so the last payload byte is index nbytes.
              if (ack_err || (byte_cnt == nbytes)) begin
                state_n = S_SP_A;
              end else begin
                state_n    = S_BIT;
                byte_cnt_n = byte_cnt + 3'd1;
              end
            end
            default: phase_n = phase_t'(phase + 2'd1);
          endcase
        end
      end
      S_SP_A: if (tick) state_n = S_SP_B;
      S_SP_B: if (tick) state_n = S_SP_C;
      S_SP_C: begin
        if (tick) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase

    // Pad levels are registered alongside the state they belong to.
    lines_n = line_levels(state_n, phase_n, shreg_n[SHIFT_W-1]);
  end

  assign SDA_O   = sda_q;
  assign SCL_O   = scl_q;
  assign BUSY    = busy;
  assign DONE    = done;
  assign ACK_ERR = ack_err;
  assign END_OK  = ~busy;

endmodule

// File: tb/tb_i2c_reg16_writer.sv
// Directed bench for i2c_reg16_writer: an I2C slave model decodes the wire and
// pops expected bytes from a scoreboard queue filled when each GO is issued.
module tb_i2c_reg16_writer;

  localparam int CLK_DIV = 3;
`ifdef I2C_WR_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 20;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  slave_addr = '0;
  logic [15:0] pointer = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  byte_num = '0;
  logic        sda_i;
  logic        scl_i = 1'b1;
  logic        sda_o, scl_o, busy, done, ack_err, end_ok;
  logic        slave_sda = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         nack_idx = -1;
  int         starts = 0;
  int         stops = 0;

  always #5 clk = ~clk;

  assign sda_i = sda_o & slave_sda;

  i2c_reg16_writer #(
    .CLK_DIV     (CLK_DIV),
    .SYNC_STAGES (2)
  ) dut (
    .CLK_50     (clk),
    .RESET_N    (rst_n),
    .GO         (go),
    .SLAVE_ADDR (slave_addr),
    .POINTER    (pointer),
    .WDATA      (wdata),
    .BYTE_NUM   (byte_num),
    .SDA_I      (sda_i),
    .SCL_I      (scl_i),
    .SDA_O      (sda_o),
    .SCL_O      (scl_o),
    .BUSY       (busy),
    .DONE       (done),
    .ACK_ERR    (ack_err),
    .END_OK     (end_ok)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model sampled on the falling clock edge, away from DUT updates.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         mbits = 0;
  int         byte_idx = 0;
  logic [7:0] shf = '0;
  logic       ack_pend = 1'b0;
  logic       ack_drv = 1'b0;

  always @(negedge clk) begin
    logic cur_scl, cur_sda;
    logic [7:0] exp_b;
    if (!rst_n) begin
      prev_scl  = 1'b1;
      prev_sda  = 1'b1;
      mbits     = 0;
      byte_idx  = 0;
      ack_pend  = 1'b0;
      ack_drv   = 1'b0;
      slave_sda = 1'b1;
    end else begin
      cur_scl = scl_o;
      cur_sda = sda_o & slave_sda;
      if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
        starts++;
        mbits    = 0;
        byte_idx = 0;
      end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
        stops++;
        mbits = 0;
      end else if (!prev_scl && cur_scl) begin
        if (mbits < 8) begin
          shf = {shf[6:0], cur_sda};
          mbits++;
          if (mbits == 8) begin
            if (exp_q.size() == 0) begin
              check("unexpected_byte", 32'(shf), 32'hFFFF_FFFF);
            end else begin
              exp_b = exp_q.pop_front();
              check("wire_byte", 32'(shf), 32'(exp_b));
            end
            ack_pend = 1'b1;
          end
        end else begin
          mbits = 0;
        end
      end else if (prev_scl && !cur_scl) begin
        if (ack_pend) begin
          slave_sda = (byte_idx == nack_idx);
          ack_pend  = 1'b0;
          ack_drv   = 1'b1;
          byte_idx++;
        end else if (ack_drv && mbits == 0) begin
          slave_sda = 1'b1;
          ack_drv   = 1'b0;
        end
      end
      prev_scl = cur_scl;
      prev_sda = sda_o & slave_sda;
    end
  end

  // One transaction; cycle 0 is the GO-sampling cycle, so the value visible
  // k edges after it belongs to cycle k+1.
  task automatic run_txn(input logic [7:0] addr, input logic [15:0] ptr, input logic [15:0] dat,
                         input logic [2:0] bnum, input int nack_at, input int go_again,
                         input int scl_low_at, input int extra, output int done_cyc);
    int n, nsent, q, cyc, vis, s0, p0, exp_done;
    logic [7:0] b[5];
    n = (bnum == 3'd0) ? 1 : ((bnum > 3'd4) ? 4 : int'(bnum));
    b[0] = addr & 8'hFE;
    b[1] = ptr[15:8];
    b[2] = ptr[7:0];
    b[3] = dat[15:8];
    b[4] = dat[7:0];
    nsent = (nack_at >= 0 && nack_at <= n) ? nack_at + 1 : n + 1;
    for (int i = 0; i < nsent; i++) exp_q.push_back(b[i]);
    q        = 2 + 36 * nsent + 3;
    exp_done = q * (CLK_DIV + 1) + 1 + extra;
    nack_idx = nack_at;
    s0 = starts;
    p0 = stops;

    @(posedge clk); #1;
    slave_addr = addr; pointer = ptr; wdata = dat; byte_num = bnum; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check("busy_after_go", 32'(busy), 32'd1);
    check("ack_err_cleared", 32'(ack_err), 32'd0);
    cyc      = 0;
    done_cyc = -1;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      vis = cyc + 1;
      if (done) begin
        done_cyc = vis;
        break;
      end
      go    = (vis == go_again);
      scl_i = !(scl_low_at > 0 && vis >= scl_low_at && vis < scl_low_at + 20);
    end
    scl_i = 1'b1;
    if (done_cyc < 0) begin
      go = 1'b0;
      check("done_timeout", 32'(cyc), 32'd0);
    end else begin
      check("done_cycle", 32'(done_cyc), 32'(exp_done));
      check("ack_err_at_done", 32'(ack_err), 32'(nsent <= n));
      check("end_ok_at_done", 32'(end_ok), 32'd1);
      // GO raised during the DONE cycle must be dropped.
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      check("go_in_done_ignored", 32'(busy), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("still_idle", 32'(busy), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("one_start", 32'(starts - s0), 32'd1);
      check("one_stop", 32'(stops - p0), 32'd1);
    end
    exp_q.delete();
  endtask

  initial begin
    int d1, d;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_scl", 32'(scl_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_end_ok", 32'(end_ok), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Full four-byte write: 1C 00 02 00 01.
    run_txn(8'h1C, 16'h0002, 16'h0001, 3'd4, -1, 0, 0, 0, d1);
    // Pointer-only write.
    run_txn(8'h1C, 16'h0000, 16'h0001, 3'd2, -1, 0, 0, 0, d);
    // Address bit0 forced low; BYTE_NUM 0 treated as 1.
    run_txn(8'h1D, 16'hA55A, 16'h1234, 3'd0, -1, 0, 0, 0, d);
    // NACK on second byte aborts to STOP.
    run_txn(8'h1C, 16'h0002, 16'h0001, 3'd4, 1, 0, 0, 0, d);
    // ACK_ERR must clear on the next GO; GO while busy at cycle 100 is ignored.
    run_txn(8'h1C, 16'h0002, 16'h0001, 3'd4, -1, 100, 0, 0, d);
    // BYTE_NUM above the limit is capped at 4.
    run_txn(8'h72, 16'hBEEF, 16'hC0DE, 3'd7, -1, 0, 0, 0, d);
    // Slave holds SCL low for 20 cycles inside the first bit's q2.
    run_txn(8'h1C, 16'h0002, 16'h0001, 3'd4, -1, 0, 15, STRETCH_EXTRA, d);
    check("stretch_vs_base", 32'(d), 32'(d1 + STRETCH_EXTRA));

    // Reset at cycle 50 with SDA driven low: lines released in the same cycle.
    nack_idx = -1;
    @(posedge clk); #1;
    slave_addr = 8'h1C; pointer = 16'h0002; wdata = 16'h0001; byte_num = 3'd4; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_sda", 32'(sda_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_reset_sda", 32'(sda_o), 32'd1);
    check("mid_reset_scl", 32'(scl_o), 32'd1);
    check("mid_reset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(posedge clk);

    // Recovery after reset: three payload bytes.
    run_txn(8'h3A, 16'h0102, 16'h0304, 3'd3, -1, 0, 0, 0, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
